// File: rtl/key_entry_sequencer_if.sv
// -----------------------------------------------------------------------------
// key_entry_sequencer_if
// Purpose : Groups the scan-code input, the coordinate handshake and the
//           status strobes of key_entry_sequencer into one bundle.
// Signals :
//   codeValid   one-cycle strobe, codeByte valid          (master -> slave)
//   codeByte    8-bit PS/2 scan code                      (master -> slave)
//   coordAck    game logic accepts the coordinate         (master -> slave)
//   coordValid  coordinate available, held until ack      (slave -> master)
//   coordLetter letter index A=0 .. J=9                   (slave -> master)
//   coordNumber digit value 0..9                          (slave -> master)
//   entryStage  0 idle, 1 letter, 2 letter+digit, 3 pend  (slave -> master)
//   entryError  one-cycle strobe on a rejected sequence   (slave -> master)
//   droppedCode one-cycle strobe on a discarded make code (slave -> master)
// Modports: master = scan-code source / game logic side, slave = sequencer.
// -----------------------------------------------------------------------------
interface key_entry_sequencer_if;
    logic       codeValid;
    logic [7:0] codeByte;
    logic       coordAck;
    logic       coordValid;
    logic [3:0] coordLetter;
    logic [3:0] coordNumber;
    logic [1:0] entryStage;
    logic       entryError;
    logic       droppedCode;

    modport master (
        output codeValid, codeByte, coordAck,
        input  coordValid, coordLetter, coordNumber, entryStage, entryError, droppedCode
    );

    modport slave (
        input  codeValid, codeByte, coordAck,
        output coordValid, coordLetter, coordNumber, entryStage, entryError, droppedCode
    );
endinterface

// File: rtl/key_entry_sequencer.sv
// -----------------------------------------------------------------------------
// key_entry_sequencer
// Purpose : Filters PS/2 break (F0) and extended (E0) sequences out of the
//           scan-code stream and sequences a three-key board coordinate entry:
//           letter A..J, digit 0..9, Enter. The finished coordinate is held on
//           a valid/ack handshake; malformed entries pulse entryError and keys
//           arriving while a coordinate is pending pulse droppedCode.
// Ports   :
//   clock50  in   system clock, all state changes on its rising edge
//   resetN   in   asynchronous active-low reset
//   bus      slave modport of key_entry_sequencer_if (scan codes in,
//            coordinate handshake and status strobes out)
// Parameters:
//   TIMEOUT_CYCLES  idle cycles allowed between keys of a partial entry
//   TO_WIDTH        width of the inactivity counter (2^TO_WIDTH > TIMEOUT_CYCLES)
// Build option:
//   KEY_ENTRY_TIMEOUT_EN  when defined, a partial entry (letter, or letter and
//   digit, held) that sees no codeValid for TIMEOUT_CYCLES cycles is abandoned
//   with an entryError pulse. When undefined, partial entries wait forever and
//   both parameters have no effect.
// -----------------------------------------------------------------------------
module key_entry_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd250000000,
    parameter int unsigned TO_WIDTH       = 32'd28
) (
    input  logic                 clock50,
    input  logic                 resetN,
    key_entry_sequencer_if.slave bus
);

    // State encoding doubles as the entryStage output value.
    localparam logic [1:0] S_LETTER  = 2'd0;
    localparam logic [1:0] S_NUMBER  = 2'd1;
    localparam logic [1:0] S_ENTER   = 2'd2;
    localparam logic [1:0] S_PENDING = 2'd3;

    localparam logic [7:0] C_BREAK = 8'hF0;
    localparam logic [7:0] C_EXT   = 8'hE0;
    localparam logic [7:0] C_ENTER = 8'h5A;
    localparam logic [7:0] C_BKSP  = 8'h66;

    // Returns {hit, index} for the letter keys A..J.
    function automatic logic [4:0] letter_lookup(input logic [7:0] code);
        logic [4:0] res;
        case (code)
            8'h1C:   res = {1'b1, 4'd0};
            8'h32:   res = {1'b1, 4'd1};
            8'h21:   res = {1'b1, 4'd2};
            8'h23:   res = {1'b1, 4'd3};
            8'h24:   res = {1'b1, 4'd4};
            8'h2B:   res = {1'b1, 4'd5};
            8'h34:   res = {1'b1, 4'd6};
            8'h33:   res = {1'b1, 4'd7};
            8'h43:   res = {1'b1, 4'd8};
            8'h3B:   res = {1'b1, 4'd9};
            default: res = {1'b0, 4'd0};
        endcase
        return res;
    endfunction

    // Returns {hit, value} for the top-row digit keys; key 0 maps to 0.
    function automatic logic [4:0] digit_lookup(input logic [7:0] code);
        logic [4:0] res;
        case (code)
            8'h45:   res = {1'b1, 4'd0};
            8'h16:   res = {1'b1, 4'd1};
            8'h1E:   res = {1'b1, 4'd2};
            8'h26:   res = {1'b1, 4'd3};
            8'h25:   res = {1'b1, 4'd4};
            8'h2E:   res = {1'b1, 4'd5};
            8'h36:   res = {1'b1, 4'd6};
            8'h3D:   res = {1'b1, 4'd7};
            8'h3E:   res = {1'b1, 4'd8};
            8'h46:   res = {1'b1, 4'd9};
            default: res = {1'b0, 4'd0};
        endcase
        return res;
    endfunction

    logic [1:0] r_state;
    logic       r_break;
    logic       r_ext;
    logic       r_coord_valid;
    logic [3:0] r_letter;
    logic [3:0] r_number;
    logic       r_error;
    logic       r_dropped;

    logic       w_is_prefix;
    logic       w_key;
    logic [4:0] w_letter_hit;
    logic [4:0] w_digit_hit;
    logic       w_is_letter;
    logic       w_is_digit;
    logic       w_is_enter;
    logic       w_is_bksp;
    logic       w_timeout;
    logic [1:0] w_state_nxt;
    logic [3:0] w_letter_nxt;
    logic [3:0] w_number_nxt;
    logic       w_error_nxt;
    logic       w_dropped_nxt;

    // A make code survives only if the byte before it was not a prefix.
    assign w_is_prefix  = (bus.codeByte == C_BREAK) || (bus.codeByte == C_EXT);
    assign w_key        = bus.codeValid && !w_is_prefix && !r_break && !r_ext;
    assign w_letter_hit = letter_lookup(bus.codeByte);
    assign w_digit_hit  = digit_lookup(bus.codeByte);
    assign w_is_letter  = w_letter_hit[4];
    assign w_is_digit   = w_digit_hit[4];
    assign w_is_enter   = (bus.codeByte == C_ENTER);
    assign w_is_bksp    = (bus.codeByte == C_BKSP);

    // An undersized counter could never reach TIMEOUT_CYCLES-1; that
    // configuration lands in this empty branch and is visible in the hierarchy.
    if ((64'd1 << TO_WIDTH) <= 64'(TIMEOUT_CYCLES)) begin : g_timeout_counter_too_narrow
    end

`ifdef KEY_ENTRY_TIMEOUT_EN
    logic [TO_WIDTH-1:0] r_to_cnt;
    logic                w_partial;

    assign w_partial = (r_state == S_NUMBER) || (r_state == S_ENTER);
    // Any byte, prefixes included, counts as activity and restarts the wait.
    assign w_timeout = w_partial && !bus.codeValid &&
                       (r_to_cnt == TO_WIDTH'(TIMEOUT_CYCLES - 32'd1));

    // Inactivity counter, only running while a partial entry is held.
    always_ff @(posedge clock50 or negedge resetN) begin
        if (!resetN) begin
            r_to_cnt <= '0;
        end else if (!w_partial || bus.codeValid || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_WIDTH'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Entry FSM: next state, coordinate latches and status strobes.
    always_comb begin
        w_state_nxt   = r_state;
        w_letter_nxt  = r_letter;
        w_number_nxt  = r_number;
        w_error_nxt   = 1'b0;
        w_dropped_nxt = 1'b0;
        case (r_state)
            S_LETTER: begin
                if (w_key && w_is_letter) begin
                    w_letter_nxt = w_letter_hit[3:0];
                    w_state_nxt  = S_NUMBER;
                end else if (w_key && w_is_digit) begin
                    w_error_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_LETTER;
                end
            end
            S_NUMBER: begin
                if (w_key && w_is_digit) begin
                    w_number_nxt = w_digit_hit[3:0];
                    w_state_nxt  = S_ENTER;
                end else if (w_key && w_is_letter) begin
                    w_letter_nxt = w_letter_hit[3:0];
                end else if (w_key && w_is_bksp) begin
                    w_state_nxt = S_LETTER;
                end else if (w_key && w_is_enter) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = S_LETTER;
                end else if (w_timeout) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = S_LETTER;
                end else begin
                    w_state_nxt = S_NUMBER;
                end
            end
            S_ENTER: begin
                if (w_key && w_is_enter) begin
                    w_state_nxt = S_PENDING;
                end else if (w_key && w_is_bksp) begin
                    w_state_nxt = S_NUMBER;
                end else if (w_key && w_is_digit) begin
                    w_number_nxt = w_digit_hit[3:0];
                end else if (w_key && w_is_letter) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = S_LETTER;
                end else if (w_timeout) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = S_LETTER;
                end else begin
                    w_state_nxt = S_ENTER;
                end
            end
            S_PENDING: begin
                // Coordinate is frozen; a key here is lost even if ack arrives with it.
                w_dropped_nxt = w_key;
                if (bus.coordAck) begin
                    w_state_nxt = S_LETTER;
                end else begin
                    w_state_nxt = S_PENDING;
                end
            end
            default: begin
                w_state_nxt = S_LETTER;
            end
        endcase
    end

    // Prefix flags: set by F0/E0, cleared by the next non-prefix byte.
    always_ff @(posedge clock50 or negedge resetN) begin
        if (!resetN) begin
            r_break <= 1'b0;
            r_ext   <= 1'b0;
        end else if (bus.codeValid && (bus.codeByte == C_BREAK)) begin
            r_break <= 1'b1;
        end else if (bus.codeValid && (bus.codeByte == C_EXT)) begin
            r_ext <= 1'b1;
        end else if (bus.codeValid) begin
            r_break <= 1'b0;
            r_ext   <= 1'b0;
        end
    end

    // State, coordinate and registered output strobes.
    always_ff @(posedge clock50 or negedge resetN) begin
        if (!resetN) begin
            r_state       <= S_LETTER;
            r_coord_valid <= 1'b0;
            r_letter      <= 4'd0;
            r_number      <= 4'd0;
            r_error       <= 1'b0;
            r_dropped     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_coord_valid <= (w_state_nxt == S_PENDING);
            r_letter      <= w_letter_nxt;
            r_number      <= w_number_nxt;
            r_error       <= w_error_nxt;
            r_dropped     <= w_dropped_nxt;
        end
    end

    assign bus.coordValid  = r_coord_valid;
    assign bus.coordLetter = r_letter;
    assign bus.coordNumber = r_number;
    assign bus.entryStage  = r_state;
    assign bus.entryError  = r_error;
    assign bus.droppedCode = r_dropped;

endmodule

// File: tb/tb_key_entry_sequencer.sv
// -----------------------------------------------------------------------------
// tb_key_entry_sequencer
// Self-checking bench for key_entry_sequencer: reset checks, a hand-written
// vector table of entry sequences, an asynchronous mid-entry reset, random
// scan-code traffic against a behavioural model, and (when built with
// KEY_ENTRY_TIMEOUT_EN) the inactivity timeout with TIMEOUT_CYCLES = 100.
// -----------------------------------------------------------------------------
module tb_key_entry_sequencer;

    logic clock50 = 1'b0;
    logic resetN  = 1'b0;

    key_entry_sequencer_if u_if ();

    key_entry_sequencer #(
        .TIMEOUT_CYCLES (32'd100),
        .TO_WIDTH       (32'd8)
    ) u_dut (
        .clock50 (clock50),
        .resetN  (resetN),
        .bus     (u_if.slave)
    );

    always #5 clock50 = ~clock50;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct packed {
        logic       v;
        logic [7:0] code;
        logic       ack;
        logic       cv;
        logic [1:0] stage;
        logic       err;
        logic       drop;
        logic [3:0] l;
        logic [3:0] n;
    } vec_t;

    vec_t tv[$];

    logic [7:0] letter_codes [10] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24,
                                      8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B};
    logic [7:0] digit_codes  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                      8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    // Behavioural model: which components of the entry are currently held.
    bit         m_brk, m_ext, m_pend, e_err, e_drop;
    int         m_hl, m_hd;
    logic [3:0] m_l, m_n;

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Apply one cycle of inputs; returns #1 after the rising edge.
    task automatic drive(input bit v, input logic [7:0] c, input bit a);
        u_if.codeValid = v;
        u_if.codeByte  = c;
        u_if.coordAck  = a;
        @(posedge clock50);
        #1;
        u_if.codeValid = 1'b0;
        u_if.coordAck  = 1'b0;
    endtask

    task automatic add(input logic v, input logic [7:0] c, input logic a, input logic cv,
                       input logic [1:0] st, input logic err, input logic drop,
                       input logic [3:0] l, input logic [3:0] n);
        vec_t t;
        t.v = v; t.code = c; t.ack = a; t.cv = cv; t.stage = st;
        t.err = err; t.drop = drop; t.l = l; t.n = n;
        tv.push_back(t);
    endtask

    task automatic model_step(input bit v, input logic [7:0] c, input bit a);
        bit is_key;
        int li, di;
        is_key = 1'b0;
        e_err  = 1'b0;
        e_drop = 1'b0;
        if (v) begin
            if (c == 8'hF0) m_brk = 1'b1;
            else if (c == 8'hE0) m_ext = 1'b1;
            else begin
                is_key = !(m_brk || m_ext);
                m_brk = 1'b0;
                m_ext = 1'b0;
            end
        end
        li = -1;
        di = -1;
        for (int i = 0; i < 10; i++) begin
            if (c == letter_codes[i]) li = i;
            if (c == digit_codes[i])  di = i;
        end
        if (m_pend) begin
            e_drop = is_key;
            if (a) begin
                m_pend = 1'b0;
                m_hl = -1;
                m_hd = -1;
            end
        end else if (is_key) begin
            if (m_hl < 0) begin
                if (li >= 0) begin m_hl = li; m_l = 4'(li); end
                else if (di >= 0) e_err = 1'b1;
            end else if (m_hd < 0) begin
                if (li >= 0) begin m_hl = li; m_l = 4'(li); end
                else if (di >= 0) begin m_hd = di; m_n = 4'(di); end
                else if (c == 8'h66) m_hl = -1;
                else if (c == 8'h5A) begin e_err = 1'b1; m_hl = -1; end
            end else begin
                if (c == 8'h5A) m_pend = 1'b1;
                else if (c == 8'h66) m_hd = -1;
                else if (di >= 0) begin m_hd = di; m_n = 4'(di); end
                else if (li >= 0) begin e_err = 1'b1; m_hl = -1; m_hd = -1; end
            end
        end
    endtask

    task automatic check_model(input int idx);
        logic [1:0] st;
        st = m_pend ? 2'd3 : (m_hd >= 0) ? 2'd2 : (m_hl >= 0) ? 2'd1 : 2'd0;
        check("rnd_valid", idx, 8'(u_if.coordValid),  8'(m_pend));
        check("rnd_stage", idx, 8'(u_if.entryStage),  8'(st));
        check("rnd_error", idx, 8'(u_if.entryError),  8'(e_err));
        check("rnd_drop",  idx, 8'(u_if.droppedCode), 8'(e_drop));
        if (m_pend) begin
            check("rnd_letter", idx, 8'(u_if.coordLetter), 8'(m_l));
            check("rnd_number", idx, 8'(u_if.coordNumber), 8'(m_n));
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_valid"},  0, 8'(u_if.coordValid),  8'd0);
        check({name, "_letter"}, 0, 8'(u_if.coordLetter), 8'd0);
        check({name, "_number"}, 0, 8'(u_if.coordNumber), 8'd0);
        check({name, "_stage"},  0, 8'(u_if.entryStage),  8'd0);
        check({name, "_error"},  0, 8'(u_if.entryError),  8'd0);
        check({name, "_drop"},   0, 8'(u_if.droppedCode), 8'd0);
    endtask

    initial begin
        logic [7:0] c;
        bit         v, a;
        int         r;

        u_if.codeValid = 1'b0;
        u_if.codeByte  = 8'h00;
        u_if.coordAck  = 1'b0;

        // Power-on reset.
        #12;
        check_all_zero("reset");
        resetN = 1'b1;
        @(posedge clock50);
        #1;

        // Asynchronous reset in the middle of an entry (S_ENTER, number 1).
        drive(1'b1, 8'h1C, 1'b0);
        drive(1'b1, 8'h16, 1'b0);
        check("mid_stage_before", 0, 8'(u_if.entryStage),  8'd2);
        check("mid_number_before", 0, 8'(u_if.coordNumber), 8'd1);
        #3;
        resetN = 1'b0;
        #1;
        check_all_zero("async_reset");
        #2;
        resetN = 1'b1;
        @(posedge clock50);
        #1;

        // Vector table: {valid, code, ack} -> {coordValid, stage, error, drop, letter, number}.
        add(1, 8'h1C, 0, 0, 2'd1, 0, 0, 4'd0, 4'd0);
        add(1, 8'hF0, 0, 0, 2'd1, 0, 0, 4'd0, 4'd0);
        add(1, 8'h1C, 0, 0, 2'd1, 0, 0, 4'd0, 4'd0);
        add(1, 8'h16, 0, 0, 2'd2, 0, 0, 4'd0, 4'd0);
        add(1, 8'hF0, 0, 0, 2'd2, 0, 0, 4'd0, 4'd0);
        add(1, 8'h16, 0, 0, 2'd2, 0, 0, 4'd0, 4'd0);
        add(1, 8'h5A, 0, 1, 2'd3, 0, 0, 4'd0, 4'd1);
        add(1, 8'hF0, 0, 1, 2'd3, 0, 0, 4'd0, 4'd1);
        add(1, 8'h5A, 0, 1, 2'd3, 0, 0, 4'd0, 4'd1);
        add(0, 8'h00, 1, 0, 2'd0, 0, 0, 4'd0, 4'd0);
        add(1, 8'hF0, 0, 0, 2'd0, 0, 0, 4'd0, 4'd0);
        add(1, 8'h32, 0, 0, 2'd0, 0, 0, 4'd0, 4'd0);
        add(1, 8'hE0, 0, 0, 2'd0, 0, 0, 4'd0, 4'd0);
        add(1, 8'h5A, 0, 0, 2'd0, 0, 0, 4'd0, 4'd0);
        add(1, 8'h43, 0, 0, 2'd1, 0, 0, 4'd0, 4'd0);
        add(1, 8'h45, 0, 0, 2'd2, 0, 0, 4'd0, 4'd0);
        add(1, 8'h5A, 0, 1, 2'd3, 0, 0, 4'd8, 4'd0);
        add(0, 8'h00, 1, 0, 2'd0, 0, 0, 4'd0, 4'd0);
        add(1, 8'h1C, 0, 0, 2'd1, 0, 0, 4'd0, 4'd0);
        add(1, 8'h66, 0, 0, 2'd0, 0, 0, 4'd0, 4'd0);
        add(1, 8'h3B, 0, 0, 2'd1, 0, 0, 4'd0, 4'd0);
        add(1, 8'h46, 0, 0, 2'd2, 0, 0, 4'd0, 4'd0);
        add(1, 8'h66, 0, 0, 2'd1, 0, 0, 4'd0, 4'd0);
        add(1, 8'h3E, 0, 0, 2'd2, 0, 0, 4'd0, 4'd0);
        add(1, 8'h5A, 0, 1, 2'd3, 0, 0, 4'd9, 4'd8);
        add(0, 8'h00, 0, 1, 2'd3, 0, 0, 4'd9, 4'd8);
        add(0, 8'h00, 1, 0, 2'd0, 0, 0, 4'd0, 4'd0);
        add(1, 8'h16, 0, 0, 2'd0, 1, 0, 4'd0, 4'd0);
        add(0, 8'h00, 0, 0, 2'd0, 0, 0, 4'd0, 4'd0);
        add(1, 8'h1C, 0, 0, 2'd1, 0, 0, 4'd0, 4'd0);
        add(1, 8'h5A, 0, 0, 2'd0, 1, 0, 4'd0, 4'd0);
        add(1, 8'h24, 0, 0, 2'd1, 0, 0, 4'd0, 4'd0);
        add(1, 8'h26, 0, 0, 2'd2, 0, 0, 4'd0, 4'd0);
        add(1, 8'h5A, 0, 1, 2'd3, 0, 0, 4'd4, 4'd3);
        add(1, 8'h24, 0, 1, 2'd3, 0, 1, 4'd4, 4'd3);
        add(1, 8'h21, 1, 0, 2'd0, 0, 1, 4'd0, 4'd0);
        add(0, 8'h00, 0, 0, 2'd0, 0, 0, 4'd0, 4'd0);
        add(1, 8'h23, 0, 0, 2'd1, 0, 0, 4'd0, 4'd0);
        add(1, 8'h1E, 0, 0, 2'd2, 0, 0, 4'd0, 4'd0);
        add(1, 8'h2B, 0, 0, 2'd0, 1, 0, 4'd0, 4'd0);
        add(1, 8'hE0, 0, 0, 2'd0, 0, 0, 4'd0, 4'd0);
        add(1, 8'h16, 0, 0, 2'd0, 0, 0, 4'd0, 4'd0);

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].v, tv[i].code, tv[i].ack);
            check("tbl_valid", i, 8'(u_if.coordValid),  8'(tv[i].cv));
            check("tbl_stage", i, 8'(u_if.entryStage),  8'(tv[i].stage));
            check("tbl_error", i, 8'(u_if.entryError),  8'(tv[i].err));
            check("tbl_drop",  i, 8'(u_if.droppedCode), 8'(tv[i].drop));
            if (tv[i].cv) begin
                check("tbl_letter", i, 8'(u_if.coordLetter), 8'(tv[i].l));
                check("tbl_number", i, 8'(u_if.coordNumber), 8'(tv[i].n));
            end
        end

        // Random traffic against the model, starting from idle with no prefix pending.
        m_brk = 1'b0; m_ext = 1'b0; m_pend = 1'b0;
        m_hl = -1; m_hd = -1; m_l = 4'd0; m_n = 4'd0;
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 9) < 7);
            a = ($urandom_range(0, 3) == 0);
            r = int'($urandom_range(0, 99));
            if (r < 35)      c = letter_codes[$urandom_range(0, 9)];
            else if (r < 65) c = digit_codes[$urandom_range(0, 9)];
            else if (r < 77) c = 8'h5A;
            else if (r < 84) c = 8'h66;
            else if (r < 89) c = 8'hF0;
            else if (r < 93) c = 8'hE0;
            else             c = 8'($urandom_range(0, 255));
            model_step(v, c, a);
            drive(v, c, a);
            check_model(i);
        end

`ifdef KEY_ENTRY_TIMEOUT_EN
        resetN = 1'b0;
        #2;
        resetN = 1'b1;
        @(posedge clock50);
        #1;
        // Letter held, then silence: abandoned on the 100th idle cycle.
        drive(1'b1, 8'h1C, 1'b0);
        for (int k = 1; k <= 99; k++) drive(1'b0, 8'h00, 1'b0);
        check("to_stage_99",  0, 8'(u_if.entryStage), 8'd1);
        check("to_error_99",  0, 8'(u_if.entryError), 8'd0);
        drive(1'b0, 8'h00, 1'b0);
        check("to_stage_100", 0, 8'(u_if.entryStage), 8'd0);
        check("to_error_100", 0, 8'(u_if.entryError), 8'd1);
        drive(1'b0, 8'h00, 1'b0);
        check("to_error_101", 0, 8'(u_if.entryError), 8'd0);
        // A prefix byte at cycle 99 restarts the count.
        drive(1'b1, 8'h1C, 1'b0);
        for (int k = 1; k <= 98; k++) drive(1'b0, 8'h00, 1'b0);
        drive(1'b1, 8'hF0, 1'b0);
        check("to_restart_stage", 0, 8'(u_if.entryStage), 8'd1);
        for (int k = 1; k <= 99; k++) drive(1'b0, 8'h00, 1'b0);
        check("to_restart_hold",  0, 8'(u_if.entryStage), 8'd1);
        check("to_restart_noerr", 0, 8'(u_if.entryError), 8'd0);
        drive(1'b0, 8'h00, 1'b0);
        check("to_restart_fire",  0, 8'(u_if.entryStage), 8'd0);
        check("to_restart_err",   0, 8'(u_if.entryError), 8'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/key_entry_sequencer.md
Name: key_entry_sequencer

Overview:
- Sits between the PS/2 scan-code receiver and the game logic.
- Consumes one 8-bit scan code per strobe, strips break (F0) and extended (E0) sequences, and sequences a three-key entry: letter A–J, then digit 0–9, then Enter.
- Presents the completed coordinate to game logic over a valid/ack handshake. Reports malformed entries on an error strobe.

Parameters:
- TIMEOUT_CYCLES, 250000000: clock50 cycles allowed between keys of a partial entry (5 s at 50 MHz); only used with KEY_ENTRY_TIMEOUT_EN.
- TO_WIDTH, 28: width of the timeout counter; must satisfy 2^TO_WIDTH > TIMEOUT_CYCLES.

Ports:
- clock50  in  1  system clock, 50 MHz; all state changes on its rising edge.
- resetN  in  1  asynchronous active-low reset.
- codeValid  in  1  one-cycle strobe; codeByte is valid this cycle (already synchronised to clock50).
- codeByte  in  8  PS/2 scan code byte.
- coordAck  in  1  game logic accepts coordinate.
- coordValid  out  1  coordinate available; held until acknowledged.
- coordLetter  out  4  letter index, A=0 … J=9.
- coordNumber  out  4  digit value, 0–9 (key 0 = 0).
- entryStage  out  2  0 = idle, 1 = letter held, 2 = letter+digit held, 3 = coordinate pending.
- entryError  out  1  one-cycle strobe on rejected sequence.
- droppedCode  out  1  one-cycle strobe when a make code is discarded while coordValid is high.

Behaviour:
- Reset (asynchronous, immediate, any state): state = S_LETTER; break and extended flags = 0; timeout counter = 0.
  - Outputs: coordValid=0, coordLetter=0, coordNumber=0, entryStage=0, entryError=0, droppedCode=0.
- Prefix filter, applied before the FSM on each codeValid:
  - F0 sets breakFlag. E0 sets extFlag. Neither reaches the FSM.
  - The next non-prefix code clears both flags.
  - That code is discarded if breakFlag or extFlag was set.
  - Only surviving make codes ("keys") advance the FSM.
- Key classes:
  - Letters: 1C 32 21 23 24 2B 34 33 43 3B map to 0–9.
  - Digits: 45 16 1E 26 25 2E 36 3D 3E 46 map to 0–9.
  - Enter: 5A. Backspace: 66.
  - Anything else is "other".
- FSM states: S_LETTER, S_NUMBER, S_ENTER, S_PENDING.
- S_LETTER:
  - letter → latch coordLetter, go to S_NUMBER.
  - backspace, Enter or other → ignore, no error.
  - digit → entryError, stay.
- S_NUMBER:
  - digit → latch coordNumber, go to S_ENTER.
  - letter → overwrite coordLetter, stay.
  - backspace → S_LETTER.
  - Enter → entryError, return to S_LETTER.
  - other → ignore.
- S_ENTER:
  - Enter → go to S_PENDING and set coordValid=1 in the same edge; latency 1 cycle after the Enter strobe.
  - backspace → S_NUMBER.
  - digit → overwrite coordNumber, stay.
  - letter → entryError, return to S_LETTER.
  - other → ignore.
- S_PENDING:
  - coordLetter and coordNumber are frozen.
  - Any key → droppedCode pulse, no state change. Prefix bytes are still tracked.
  - coordAck=1 → coordValid=0 next edge, go to S_LETTER.
  - coordAck outside S_PENDING is ignored.
- Simultaneous events:
  - codeValid and coordAck in the same S_PENDING cycle: ack is taken, the key is dropped with droppedCode=1, next state is S_LETTER.
- entryStage equals the state encoding: S_LETTER=0, S_NUMBER=1, S_ENTER=2, S_PENDING=3.
- coordLetter and coordNumber keep their last values after returning to S_LETTER. They are meaningful only while coordValid=1.
- entryError and droppedCode are registered and high for exactly one cycle.

Optional Feature:
- Macro KEY_ENTRY_TIMEOUT_EN.
- Defined:
  - In S_NUMBER or S_ENTER, a counter increments every cycle without an accepted key. Any codeValid, prefix bytes included, resets it to 0.
  - When the counter reaches TIMEOUT_CYCLES-1: return to S_LETTER, pulse entryError, clear the counter.
  - The counter holds at 0 in S_LETTER and S_PENDING.
- Undefined: no counter logic, partial entries wait indefinitely, TIMEOUT_CYCLES and TO_WIDTH are unused.

Test Plan:
- Reset mid-entry: reach S_ENTER with 1C,16; assert resetN=0 asynchronously → all outputs 0 immediately, entryStage=0.
- Basic entry: 1C, F0,1C, 16, F0,16, 5A, F0,5A → coordValid=1 one cycle after 5A, coordLetter=0, coordNumber=1; coordAck → coordValid=0 next cycle, entryStage=0.
- Break/extended filtering: F0,32 then E0,5A then 43, 45, 5A → break and extended codes are ignored; coordinate is letter 8, number 0.
- Edits and errors:
  - 1C, 66, 3B, 46, 66, 3E, 5A → coordinate letter 9, number 8.
  - 16 in S_LETTER → entryError pulse.
  - 1C then 5A → entryError, entryStage=0.
- Pending and simultaneous events: while coordValid=1, send 24 → droppedCode pulse, coordinate unchanged; then 21 with coordAck in the same cycle → droppedCode=1, coordValid=0, entryStage=0.
- Timeout (with KEY_ENTRY_TIMEOUT_EN, TIMEOUT_CYCLES=100): send 1C, then no codes → entryError at cycle 100, entryStage=0; a code at cycle 99 restarts the count.
